// File: rtl/blur.sv
// ---------------------------------------------------------------------------
// blur -- streaming 3x3 Gaussian blur over a raster-order pixel stream.
//
// Kernel [1 2 1; 2 4 2; 1 2 1], 12-bit unsigned accumulation, result / 16.
// Two line buffers hold the previous two rows.  A two-column window register
// holds columns c-2 and c-1; the live input column (two line-buffer reads
// plus the incoming pixel) completes the 3x3 window.  Results appear one
// cycle after the completing pixel is accepted, and only for interior
// windows.
//
// Configuration macro:
//   BLUR_ROUND_EN  defined   -> o_pixel = (sum + 8) >> 4  (round half up)
//                  undefined -> o_pixel = sum >> 4        (truncate)
//
// Parameters:
//   MAX_WIDTH  maximum pixels per row (line-buffer depth)
//   PIX_W      pixel width in bits (8)
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset; also the frame boundary
//   i_valid    i_pixel / i_row_end accepted this cycle; low = stall
//   i_pixel    input pixel, unsigned, raster order
//   i_row_end  last pixel of the current row (qualified by i_valid)
//   o_valid    one-cycle pulse per blurred result
//   o_pixel    blurred pixel, holds its value while o_valid is low
// ---------------------------------------------------------------------------
module blur #(
    parameter int MAX_WIDTH = 256,
    parameter int PIX_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_row_end,
    output logic             o_valid,
    output logic [PIX_W-1:0] o_pixel
);

    localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int CW    = $clog2(MAX_WIDTH + 1);
    localparam int SUM_W = PIX_W + 4;
    localparam int ROW_W = 16;

    // Position tracking
    logic [CW-1:0]    col;
    logic [ROW_W-1:0] row;
    // Lengths of rows r-1 and r-2.  Zero means "not seen yet", so the
    // learned width W of row 0 lands in len_prev1 on the first i_row_end
    // and reset returns W to unlearned.
    logic [CW-1:0]    len_prev1;
    logic [CW-1:0]    len_prev2;

    // Line buffers: lb_mid holds row r-1, lb_top holds row r-2
    logic [PIX_W-1:0] lb_mid [MAX_WIDTH];
    logic [PIX_W-1:0] lb_top [MAX_WIDTH];

    // Window columns: left = column c-2, cen = column c-1
    logic [PIX_W-1:0] left_top, left_mid, left_bot;
    logic [PIX_W-1:0] cen_top, cen_mid, cen_bot;

    logic             in_range;
    logic             take;
    logic             fire;
    logic [AW-1:0]    idx;
    logic [PIX_W-1:0] top_rd;
    logic [PIX_W-1:0] mid_rd;
    logic [CW-1:0]    row_len;
    logic [SUM_W-1:0] sum;

    function automatic logic [PIX_W-1:0] scale(input logic [SUM_W-1:0] s);
`ifdef BLUR_ROUND_EN
        return PIX_W'((s + SUM_W'(8)) >> 4);
`else
        return PIX_W'(s >> 4);
`endif
    endfunction

    always_comb begin
        in_range = (col < CW'(MAX_WIDTH));
        take     = i_valid && in_range;
        idx      = col[AW-1:0];
        top_rd   = lb_top[idx];
        mid_rd   = lb_mid[idx];
        // Over-width pixels do not lengthen the stored row
        row_len  = in_range ? (col + CW'(1)) : col;
        // Interior window only, and only where both buffered rows actually
        // reached this column, so stale buffer contents never reach o_pixel.
        fire     = take
                   && (row >= ROW_W'(2))
                   && (col >= CW'(2))
                   && (col < len_prev1)
                   && (col < len_prev2);
        sum      = SUM_W'(left_top)
                 + (SUM_W'(left_mid) << 1)
                 + SUM_W'(left_bot)
                 + (SUM_W'(cen_top) << 1)
                 + (SUM_W'(cen_mid) << 2)
                 + (SUM_W'(cen_bot) << 1)
                 + SUM_W'(top_rd)
                 + (SUM_W'(mid_rd) << 1)
                 + SUM_W'(i_pixel);
    end

    // Counters and row lengths
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col       <= '0;
            row       <= '0;
            len_prev1 <= '0;
            len_prev2 <= '0;
        end else if (i_valid) begin
            if (i_row_end) begin
                col       <= '0;
                if (row != {ROW_W{1'b1}})
                    row <= row + ROW_W'(1);
                len_prev1 <= row_len;
                len_prev2 <= len_prev1;
            end else if (in_range) begin
                // Saturates at MAX_WIDTH; everything past it is ignored
                col <= col + CW'(1);
            end
        end
    end

    // Window shift, once per in-range accepted pixel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left_top <= '0;
            left_mid <= '0;
            left_bot <= '0;
            cen_top  <= '0;
            cen_mid  <= '0;
            cen_bot  <= '0;
        end else if (take) begin
            left_top <= cen_top;
            left_mid <= cen_mid;
            left_bot <= cen_bot;
            cen_top  <= top_rd;
            cen_mid  <= mid_rd;
            cen_bot  <= i_pixel;
        end
    end

    // Line buffers: row r-1 moves up to r-2, the new pixel becomes r-1
    always_ff @(posedge i_clk) begin
        if (take) begin
            lb_top[idx] <= mid_rd;
            lb_mid[idx] <= i_pixel;
        end
    end

    // Output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_pixel <= '0;
        end else begin
            o_valid <= fire;
            if (fire)
                o_pixel <= scale(sum);
        end
    end

endmodule

// File: tb/tb_blur.sv
// ---------------------------------------------------------------------------
// tb_blur -- directed self-checking bench for blur (MAX_WIDTH = 4).
// Every pixel is driven for one clock; outputs are sampled 1 time unit after
// the rising edge, so a result is expected in the sample taken right after
// its completing pixel.
// ---------------------------------------------------------------------------
module tb_blur;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic [7:0] i_pixel;
    logic       i_row_end;
    logic       o_valid;
    logic [7:0] o_pixel;

    int n_cmp;
    int n_fail;

`ifdef BLUR_ROUND_EN
    localparam logic [7:0] EXP_ROUND = 8'd1;
`else
    localparam logic [7:0] EXP_ROUND = 8'd0;
`endif

    blur #(.MAX_WIDTH(4), .PIX_W(8)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_pixel   (i_pixel),
        .i_row_end (i_row_end),
        .o_valid   (o_valid),
        .o_pixel   (o_pixel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic send(input logic [7:0] p, input logic re,
                        output logic ov, output logic [7:0] op);
        i_valid   = 1'b1;
        i_pixel   = p;
        i_row_end = re;
        @(posedge i_clk);
        #1;
        ov        = o_valid;
        op        = o_pixel;
        i_valid   = 1'b0;
        i_row_end = 1'b0;
    endtask

    task automatic idle(output logic ov, output logic [7:0] op);
        i_valid   = 1'b0;
        i_pixel   = 8'hEE;
        i_row_end = 1'b1;
        @(posedge i_clk);
        #1;
        ov        = o_valid;
        op        = o_pixel;
        i_row_end = 1'b0;
    endtask

    task automatic apply_reset();
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        n_cmp++;
        if (o_pixel !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_pixel: got %0d want 0", o_pixel);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_constant();
        logic ov;
        logic [7:0] op;
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(8'd100, c == 3, ov, op);
                n_cmp++;
                if (ov !== ((r >= 2) && (c >= 2))) begin
                    n_fail++;
                    $display("FAIL const_valid r%0d c%0d: got %b want %b", r, c, ov, (r >= 2) && (c >= 2));
                end
                if ((r >= 2) && (c >= 2)) begin
                    n_cmp++;
                    if (op !== 8'd100) begin
                        n_fail++;
                        $display("FAIL const_pixel r%0d c%0d: got %0d want 100", r, c, op);
                    end
                end
                if (ov === 1'b1) outs++;
            end
        end
        n_cmp++;
        if (outs !== 4) begin
            n_fail++;
            $display("FAIL const_count: got %0d want 4", outs);
        end
    endtask

    task automatic test_gradient();
        logic ov;
        logic [7:0] op;
        logic [7:0] exp_px [4] = '{8'd0, 8'd0, 8'd16, 8'd32};
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(8'(c * 16), c == 3, ov, op);
                n_cmp++;
                if (ov !== ((r == 2) && (c >= 2))) begin
                    n_fail++;
                    $display("FAIL grad_valid r%0d c%0d: got %b want %b", r, c, ov, (r == 2) && (c >= 2));
                end
                if ((r == 2) && (c >= 2)) begin
                    n_cmp++;
                    if (op !== exp_px[c]) begin
                        n_fail++;
                        $display("FAIL grad_pixel c%0d: got %0d want %0d", c, op, exp_px[c]);
                    end
                end
                if (ov === 1'b1) outs++;
            end
        end
        n_cmp++;
        if (outs !== 2) begin
            n_fail++;
            $display("FAIL grad_count: got %0d want 2", outs);
        end
    endtask

    task automatic test_rounding();
        logic ov;
        logic [7:0] op;
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                send(((r == 1) && (c == 1)) ? 8'd3 : 8'd0, c == 2, ov, op);
                if (ov === 1'b1) outs++;
            end
        end
        n_cmp++;
        if (outs !== 1) begin
            n_fail++;
            $display("FAIL round_count: got %0d want 1", outs);
        end
        n_cmp++;
        if (op !== EXP_ROUND) begin
            n_fail++;
            $display("FAIL round_pixel: got %0d want %0d", op, EXP_ROUND);
        end
    endtask

    task automatic test_stall();
        logic ov;
        logic [7:0] op;
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((r == 2) && (c == 3)) begin
                    for (int s = 0; s < 3; s++) begin
                        idle(ov, op);
                        n_cmp++;
                        if (ov !== 1'b0) begin
                            n_fail++;
                            $display("FAIL stall_valid s%0d: got %b want 0", s, ov);
                        end
                        n_cmp++;
                        if (op !== 8'd100) begin
                            n_fail++;
                            $display("FAIL stall_hold s%0d: got %0d want 100", s, op);
                        end
                    end
                end
                send(8'd100, c == 3, ov, op);
                n_cmp++;
                if (ov !== ((r >= 2) && (c >= 2))) begin
                    n_fail++;
                    $display("FAIL stall_out_valid r%0d c%0d: got %b want %b", r, c, ov, (r >= 2) && (c >= 2));
                end
                if ((r >= 2) && (c >= 2)) begin
                    n_cmp++;
                    if (op !== 8'd100) begin
                        n_fail++;
                        $display("FAIL stall_pixel r%0d c%0d: got %0d want 100", r, c, op);
                    end
                end
                if (ov === 1'b1) outs++;
            end
        end
        n_cmp++;
        if (outs !== 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 4", outs);
        end
    endtask

    task automatic test_mid_reset();
        logic ov;
        logic [7:0] op;
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((r < 2) || (c < 3)) send(8'd100, c == 3, ov, op);
            end
        end
        n_cmp++;
        if ((ov !== 1'b1) || (op !== 8'd100)) begin
            n_fail++;
            $display("FAIL midrst_pre: got v=%b p=%0d want v=1 p=100", ov, op);
        end
        // Assert reset between edges: outputs must clear without a clock
        i_rst_n = 1'b0;
        #2;
        n_cmp++;
        if ((o_valid !== 1'b0) || (o_pixel !== 8'd0)) begin
            n_fail++;
            $display("FAIL midrst_async: got v=%b p=%0d want v=0 p=0", o_valid, o_pixel);
        end
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold: got %b want 0", o_valid);
        end
        i_rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                send(8'd50, c == 2, ov, op);
                n_cmp++;
                if (ov !== ((r == 2) && (c == 2))) begin
                    n_fail++;
                    $display("FAIL midrst_valid r%0d c%0d: got %b want %b", r, c, ov, (r == 2) && (c == 2));
                end
                if (ov === 1'b1) outs++;
            end
        end
        n_cmp++;
        if ((outs !== 1) || (op !== 8'd50)) begin
            n_fail++;
            $display("FAIL midrst_result: got count=%0d p=%0d want count=1 p=50", outs, op);
        end
    endtask

    task automatic test_over_width();
        logic ov;
        logic [7:0] op;
        int outs = 0;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) begin
                send((c < 4) ? 8'd40 : 8'd240, c == 5, ov, op);
                n_cmp++;
                if (ov !== ((r >= 2) && (c >= 2) && (c < 4))) begin
                    n_fail++;
                    $display("FAIL ovw_valid r%0d c%0d: got %b want %b", r, c, ov, (r >= 2) && (c >= 2) && (c < 4));
                end
                if (ov === 1'b1) begin
                    outs++;
                    n_cmp++;
                    if (op !== 8'd40) begin
                        n_fail++;
                        $display("FAIL ovw_pixel r%0d c%0d: got %0d want 40", r, c, op);
                    end
                end
            end
        end
        n_cmp++;
        if (outs !== 4) begin
            n_fail++;
            $display("FAIL ovw_count: got %0d want 4", outs);
        end
    endtask

    task automatic test_short_rows();
        logic ov;
        logic [7:0] op;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                send(8'd200, c == 1, ov, op);
                n_cmp++;
                if (ov !== 1'b0) begin
                    n_fail++;
                    $display("FAIL short_valid r%0d c%0d: got %b want 0", r, c, ov);
                end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_pixel   = 8'd0;
        i_row_end = 1'b0;
        test_reset();
        test_constant();
        test_gradient();
        test_rounding();
        test_stall();
        test_mid_reset();
        test_over_width();
        test_short_rows();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/blur.md
BLUR -- requirements
Module: blur

Interface
- REQ-001 SHALL have parameter MAX_WIDTH, default 256: maximum pixels per row, which sets the line-buffer depth.
- REQ-002 SHALL have parameter PIX_W, default 8: pixel width in bits; all requirements below assume 8.
- REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- REQ-004 SHALL have port i_clk, input, 1 bit: the clock; all state updates on its rising edge.
- REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port i_valid, input, 1 bit: i_pixel and i_row_end are accepted on this cycle.
- REQ-007 SHALL have port i_pixel, input, 8 bits: input pixel, raster order, unsigned.
- REQ-008 SHALL have port i_row_end, input, 1 bit: marks the last pixel of the current row; qualified by i_valid.
- REQ-009 SHALL have port o_valid, output, 1 bit: o_pixel is valid this cycle (one-cycle pulse per result).
- REQ-010 SHALL have port o_pixel, output, 8 bits: blurred output pixel.

Function
- REQ-011 SHALL compute a 3x3 Gaussian blur over the input stream.
  - Kernel weights: [1 2 1; 2 4 2; 1 2 1].
  - Sum width: 12 bits unsigned, so no overflow is possible.
  - Result: sum/16 (see REQ-024 for rounding); never exceeds 255.
- REQ-012 SHALL track the input position with a row counter and a column counter, both starting at 0 after reset.
  - Each accepted pixel increments the column counter.
  - An accepted pixel with i_row_end=1 clears the column counter and increments the row counter.
- REQ-013 SHALL learn the row width W from the first row: the number of pixels up to and including the first i_row_end.
  - Later rows are delimited only by i_row_end.
- REQ-014 SHALL keep the two previous rows in line buffers of MAX_WIDTH entries, indexed by column.
  - Also keep a 3x3 window register, shifted once per accepted pixel.
- REQ-015 SHALL produce output only for interior windows.
  - An accepted pixel at row r>=2 and column c>=2 completes the window centred on (r-1, c-1).
  - Edge pixels produce no output; a WxH frame yields (W-2)x(H-2) outputs.
- REQ-016 SHALL register the result: o_valid=1 and o_pixel valid exactly one cycle after the accepting edge of the completing pixel.
  - Otherwise o_valid=0.
  - o_pixel holds its last value when o_valid=0.
- REQ-017 SHALL treat a cycle with i_valid=0 as a stall: no counter, buffer or window change.
  - i_pixel and i_row_end are ignored on that cycle.
  - Stalls may occur anywhere, including mid-row.
- REQ-018 SHALL ignore pixels at columns >= MAX_WIDTH (no buffer write, no output) until the next i_row_end.
- REQ-019 SHALL support minimum width 3.
  - Rows shorter than 3 pixels produce no output.
  - They still advance the row counter.
- REQ-020 SHALL treat reset as the frame boundary; there is no frame-start input.
  - The row counter saturates at its maximum and does not wrap.

Reset
- REQ-021 SHALL, while i_rst_n=0, force the following immediately (asynchronously):
  - o_valid=0 and o_pixel=0;
  - row counter, column counter and window registers to 0;
  - W to unlearned.
- REQ-022 SHALL NOT require line-buffer contents to be cleared; stale contents are never used for output.
- REQ-023 SHALL, on reset asserted mid-frame, discard any partial frame.
  - The first accepted pixel after release is row 0, column 0.

Configuration
- REQ-024 SHALL select rounding with macro BLUR_ROUND_EN.
  - Defined: o_pixel = (sum+8)>>4 (round half up).
  - Undefined: o_pixel = sum>>4 (truncation).

Verification
- REQ-025 SHALL cover a constant frame: 4x4 frame, all pixels 100, i_row_end on every 4th pixel -> exactly four o_valid pulses, each o_pixel=100.
- REQ-026 SHALL cover a gradient frame: 4x3 frame, pixel = column*16 -> two outputs, o_pixel=16 then 32.
- REQ-027 SHALL cover rounding: 3x3 frame, centre 3, others 0 -> single output, o_pixel=1 with BLUR_ROUND_EN, 0 without.
- REQ-028 SHALL cover stalls: REQ-025 stimulus with i_valid deasserted for 3 cycles mid-row 2 -> same four values.
  - Each output arrives 1 cycle after its completing pixel.
- REQ-029 SHALL cover mid-frame reset: pulse i_rst_n low during row 2, then send a fresh 3x3 frame of all 50 -> o_valid=0 during reset, then exactly one output of 50.
- REQ-030 SHALL cover over-width rows: MAX_WIDTH=4, rows of 6 pixels -> no writes or outputs for columns 4-5, and no corruption of the next row.
